// File: rtl/dmem_arb_pkg.sv
// Shared constants and state encoding for the data-memory arbiter.
// Imported by the arbiter top and its starvation counter.
package dmem_arb_pkg;

    localparam int DEF_ADDR_W   = 8;
    localparam int DEF_DATA_W   = 16;
    localparam int DEF_MAX_WAIT = 4;

    // Wide enough for the largest supported MAX_WAIT (15).
    localparam int WAIT_W = 4;

    typedef enum logic [1:0] {
        ST_CPU_PRI   = 2'd0,
        ST_DBG_FORCE = 2'd1,
        ST_DBG_LOCK  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of consecutive cycles the debug port was denied.
// at_limit flags that one more denied cycle reaches MAX_WAIT on this edge.
module arb_starve_cnt
    import dmem_arb_pkg::*;
#(
    parameter int MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              clr,
    output logic [WAIT_W-1:0] cnt,
    output logic              at_limit
);

    localparam logic [WAIT_W-1:0] MAX_V    = WAIT_W'(MAX_WAIT);
    localparam logic [WAIT_W-1:0] MAX_M1_V = WAIT_W'(MAX_WAIT - 1);
    localparam logic [WAIT_W-1:0] ONE_V    = WAIT_W'(1);

    assign at_limit = (cnt >= MAX_M1_V);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != MAX_V)) begin
            cnt <= cnt + ONE_V;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory: CPU has fixed
// priority, debug gets bounded latency via a starvation counter and a burst lock.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    input  logic              dbg_lock,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        arb_state,
    output logic [WAIT_W-1:0] arb_wait_cnt
);

    // Handshake: a port's req/we/addr/wdata must stay stable while req is high
    // and gnt is low; the access happens in the cycle where req & gnt are both
    // high, and a granted load returns rvalid exactly one cycle later.

    arb_state_e        state;
    arb_state_e        state_nxt;
    logic              pri_mode;
    logic              wait_inc;
    logic              wait_clr;
    logic              at_limit;
    logic [WAIT_W-1:0] wait_cnt;

    arb_starve_cnt #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve_cnt (
        .clk      (clk),
        .rst      (rst),
        .inc      (wait_inc),
        .clr      (wait_clr),
        .cnt      (wait_cnt),
        .at_limit (at_limit)
    );

    assign wait_inc = dbg_req & ~dbg_gnt;
    assign wait_clr = dbg_gnt | ~dbg_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_CPU_PRI;
        end else begin
            state <= state_nxt;
        end
    end

    // pri_mode selects normal CPU-first arbitration; the forced and locked
    // states fall back to it when debug no longer holds its claim.
    always_comb begin
        cpu_gnt   = 1'b0;
        dbg_gnt   = 1'b0;
        pri_mode  = 1'b0;
        state_nxt = state;
        if (!rst) begin
            case (state)
                ST_CPU_PRI: begin
                    pri_mode = 1'b1;
                end
                ST_DBG_FORCE: begin
                    if (dbg_req) begin
                        dbg_gnt   = 1'b1;
                        state_nxt = dbg_lock ? ST_DBG_LOCK : ST_CPU_PRI;
                    end else begin
                        pri_mode = 1'b1;
                    end
                end
                ST_DBG_LOCK: begin
                    if (dbg_lock) begin
                        dbg_gnt = dbg_req;
                    end else begin
                        pri_mode = 1'b1;
                    end
                end
                default: begin
                    state_nxt = ST_CPU_PRI;
                end
            endcase

            if (pri_mode) begin
                state_nxt = ST_CPU_PRI;
                if (cpu_req) begin
                    cpu_gnt = 1'b1;
                    if (dbg_req && at_limit) begin
                        state_nxt = ST_DBG_FORCE;
                    end
                end else if (dbg_req) begin
                    dbg_gnt = 1'b1;
                    if (dbg_lock) begin
                        state_nxt = ST_DBG_LOCK;
                    end
                end
            end
        end
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (dbg_gnt) begin
            mem_we    = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
        end
    end

    assign mem_en    = cpu_gnt | dbg_gnt;
    assign cpu_stall = cpu_req & ~cpu_gnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_rvalid <= 1'b0;
            dbg_rvalid <= 1'b0;
        end else begin
            cpu_rvalid <= cpu_gnt & ~cpu_we;
            dbg_rvalid <= dbg_gnt & ~dbg_we;
        end
    end

    assign cpu_rdata    = mem_rdata;
    assign dbg_rdata    = mem_rdata;
    assign arb_state    = state;
    assign arb_wait_cnt = wait_cnt;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural memory and a CPU
// read-data scoreboard.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    logic        clk;
    logic        rst;
    logic        cpu_req, cpu_we;
    logic [7:0]  cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_gnt, cpu_stall, cpu_rvalid;
    logic [15:0] cpu_rdata;
    logic        dbg_req, dbg_we, dbg_lock;
    logic [7:0]  dbg_addr;
    logic [15:0] dbg_wdata;
    logic        dbg_gnt, dbg_rvalid;
    logic [15:0] dbg_rdata;
    logic        mem_en, mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic [1:0]  arb_state;
    logic [3:0]  arb_wait_cnt;

    logic [15:0] mem [256];
    logic [15:0] exp_q[$];
    int          n_vec;
    int          n_err;

    dmem_arbiter #(
        .ADDR_W   (8),
        .DATA_W   (16),
        .MAX_WAIT (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_req      (cpu_req),
        .cpu_we       (cpu_we),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_gnt      (cpu_gnt),
        .cpu_stall    (cpu_stall),
        .cpu_rvalid   (cpu_rvalid),
        .cpu_rdata    (cpu_rdata),
        .dbg_req      (dbg_req),
        .dbg_we       (dbg_we),
        .dbg_addr     (dbg_addr),
        .dbg_wdata    (dbg_wdata),
        .dbg_lock     (dbg_lock),
        .dbg_gnt      (dbg_gnt),
        .dbg_rvalid   (dbg_rvalid),
        .dbg_rdata    (dbg_rdata),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .arb_state    (arb_state),
        .arb_wait_cnt (arb_wait_cnt)
    );

    // clock / reset-time memory preload
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) begin
                mem[i] <= (i == 16) ? 16'hBEEF : 16'h0000;
            end
        end else if (mem_en) begin
            if (mem_we) begin
                mem[mem_addr] <= mem_wdata;
            end else begin
                mem_rdata <= mem[mem_addr];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_drive(input logic req, input logic we, input logic [7:0] addr,
                             input logic [15:0] wdata);
        cpu_req   = req;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
    endtask

    task automatic dbg_drive(input logic req, input logic we, input logic [7:0] addr,
                             input logic [15:0] wdata, input logic lock);
        dbg_req   = req;
        dbg_we    = we;
        dbg_addr  = addr;
        dbg_wdata = wdata;
        dbg_lock  = lock;
    endtask

    // scoreboard: every CPU rvalid pops one expected load value
    always @(negedge clk) begin
        if (cpu_rvalid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("cpu_rvalid_unexpected", 32'd1, 32'd0);
            end else begin
                check("cpu_rdata", cpu_rdata, exp_q.pop_front());
            end
        end
    end

    logic [8:0]  burst_tab [5];

    initial begin
        n_vec = 0;
        n_err = 0;
        burst_tab[0] = {1'b1, 8'h00};
        burst_tab[1] = {1'b1, 8'h01};
        burst_tab[2] = {1'b0, 8'h00};
        burst_tab[3] = {1'b1, 8'h02};
        burst_tab[4] = {1'b1, 8'h03};

        // reset with both ports requesting
        rst = 1'b1;
        cpu_drive(1'b1, 1'b0, 8'h10, 16'h0);
        dbg_drive(1'b1, 1'b0, 8'h20, 16'h0, 1'b0);
        @(negedge clk);
        check("rst_cpu_gnt", cpu_gnt, 0);
        check("rst_dbg_gnt", dbg_gnt, 0);
        check("rst_mem_en", mem_en, 0);
        cyc();
        cyc();
        rst = 1'b0;
        cpu_drive(1'b0, 1'b0, 8'h0, 16'h0);
        dbg_drive(1'b0, 1'b0, 8'h0, 16'h0, 1'b0);
        @(negedge clk);
        check("rst_cpu_rvalid", cpu_rvalid, 0);
        check("rst_dbg_rvalid", dbg_rvalid, 0);
        check("rst_state", arb_state, ST_CPU_PRI);
        check("rst_wait_cnt", arb_wait_cnt, 0);
        check("idle_mem_addr", mem_addr, 0);

        // CPU load of 0x10
        cyc();
        cpu_drive(1'b1, 1'b0, 8'h10, 16'h0);
        exp_q.push_back(16'hBEEF);
        @(negedge clk);
        check("load_cpu_gnt", cpu_gnt, 1);
        check("load_mem_en", mem_en, 1);
        check("load_mem_we", mem_we, 0);
        check("load_mem_addr", mem_addr, 8'h10);
        check("load_cpu_stall", cpu_stall, 0);
        cyc();
        cpu_drive(1'b0, 1'b0, 8'h0, 16'h0);
        @(negedge clk);
        check("load_cpu_rvalid", cpu_rvalid, 1);
        check("load_dbg_rvalid", dbg_rvalid, 0);
        check("load_idle_mem_en", mem_en, 0);

        // simultaneous requests, then starvation forces debug on cycle 5
        cyc();
        cpu_drive(1'b1, 1'b0, 8'h10, 16'h0);
        dbg_drive(1'b1, 1'b1, 8'h20, 16'h1234, 1'b0);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(16'hBEEF);
            @(negedge clk);
            check("starve_cpu_gnt", cpu_gnt, 1);
            check("starve_dbg_gnt", dbg_gnt, 0);
            check("starve_wait_cnt", arb_wait_cnt, i);
            cyc();
        end
        @(negedge clk);
        check("force_state", arb_state, ST_DBG_FORCE);
        check("force_dbg_gnt", dbg_gnt, 1);
        check("force_cpu_gnt", cpu_gnt, 0);
        check("force_cpu_stall", cpu_stall, 1);
        check("force_wait_cnt", arb_wait_cnt, 4);
        check("force_mem_we", mem_we, 1);
        check("force_mem_addr", mem_addr, 8'h20);
        check("force_mem_wdata", mem_wdata, 16'h1234);
        cyc();
        dbg_drive(1'b0, 1'b0, 8'h0, 16'h0, 1'b0);
        exp_q.push_back(16'hBEEF);
        @(negedge clk);
        check("regrant_cpu_gnt", cpu_gnt, 1);
        check("regrant_state", arb_state, ST_CPU_PRI);
        check("regrant_wait_cnt", arb_wait_cnt, 0);
        check("dbg_write_no_rvalid", dbg_rvalid, 0);
        cyc();
        cpu_drive(1'b1, 1'b0, 8'h20, 16'h0);
        exp_q.push_back(16'h1234);
        @(negedge clk);
        check("rd20_cpu_gnt", cpu_gnt, 1);
        cyc();
        cpu_drive(1'b0, 1'b0, 8'h0, 16'h0);

        // debug load of 0x20 while CPU idle
        dbg_drive(1'b1, 1'b0, 8'h20, 16'h0, 1'b0);
        @(negedge clk);
        check("dbg_rd_gnt", dbg_gnt, 1);
        cyc();
        dbg_drive(1'b0, 1'b0, 8'h0, 16'h0, 1'b0);
        @(negedge clk);
        check("dbg_rd_rvalid", dbg_rvalid, 1);
        check("dbg_rd_rdata", dbg_rdata, 16'h1234);
        check("dbg_rd_cpu_rvalid", cpu_rvalid, 0);

        // CPU store produces no rvalid, later load reads it back
        cyc();
        cpu_drive(1'b1, 1'b1, 8'h05, 16'h00FF);
        @(negedge clk);
        check("st_cpu_gnt", cpu_gnt, 1);
        check("st_mem_we", mem_we, 1);
        check("st_mem_addr", mem_addr, 8'h05);
        check("st_mem_wdata", mem_wdata, 16'h00FF);
        cyc();
        cpu_drive(1'b0, 1'b0, 8'h0, 16'h0);
        @(negedge clk);
        check("st_cpu_rvalid", cpu_rvalid, 0);
        check("st_dbg_rvalid", dbg_rvalid, 0);
        cyc();
        cpu_drive(1'b1, 1'b0, 8'h05, 16'h0);
        exp_q.push_back(16'h00FF);
        @(negedge clk);
        check("ld05_cpu_gnt", cpu_gnt, 1);
        cyc();
        cpu_drive(1'b0, 1'b0, 8'h0, 16'h0);

        // debug lock burst with a bubble, CPU requesting throughout
        cpu_drive(1'b1, 1'b0, 8'h10, 16'h0);
        dbg_drive(1'b1, 1'b1, 8'h00, 16'hA000, 1'b1);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(16'hBEEF);
            @(negedge clk);
            check("lock_pre_cpu_gnt", cpu_gnt, 1);
            cyc();
        end
        for (int k = 0; k < 5; k++) begin
            dbg_drive(burst_tab[k][8], 1'b1, burst_tab[k][7:0],
                      16'hA000 | {8'h00, burst_tab[k][7:0]}, 1'b1);
            @(negedge clk);
            check("lock_cpu_gnt", cpu_gnt, 0);
            check("lock_cpu_stall", cpu_stall, 1);
            check("lock_dbg_gnt", dbg_gnt, burst_tab[k][8]);
            check("lock_state", arb_state, (k == 0) ? ST_DBG_FORCE : ST_DBG_LOCK);
            cyc();
        end
        dbg_drive(1'b0, 1'b0, 8'h0, 16'h0, 1'b0);
        exp_q.push_back(16'hBEEF);
        @(negedge clk);
        check("unlock_cpu_gnt", cpu_gnt, 1);
        cyc();
        cpu_drive(1'b0, 1'b0, 8'h0, 16'h0);
        @(negedge clk);
        check("unlock_state", arb_state, ST_CPU_PRI);
        for (int a = 0; a < 4; a++) begin
            cyc();
            cpu_drive(1'b1, 1'b0, 8'(a), 16'h0);
            exp_q.push_back(16'hA000 + 16'(a));
            @(negedge clk);
            check("burst_rd_cpu_gnt", cpu_gnt, 1);
        end
        cyc();
        cpu_drive(1'b0, 1'b0, 8'h0, 16'h0);
        @(negedge clk);

        // reset while a load is outstanding
        cyc();
        cpu_drive(1'b1, 1'b0, 8'h10, 16'h0);
        dbg_drive(1'b1, 1'b1, 8'h30, 16'h5555, 1'b0);
        exp_q.push_back(16'hBEEF);
        @(negedge clk);
        check("prerst_cpu_gnt", cpu_gnt, 1);
        cyc();
        rst = 1'b1;
        @(negedge clk);
        check("midrst_wait_cnt", arb_wait_cnt, 1);
        check("midrst_cpu_gnt", cpu_gnt, 0);
        check("midrst_dbg_gnt", dbg_gnt, 0);
        check("midrst_mem_en", mem_en, 0);
        cyc();
        rst = 1'b0;
        cpu_drive(1'b0, 1'b0, 8'h0, 16'h0);
        dbg_drive(1'b0, 1'b0, 8'h0, 16'h0, 1'b0);
        @(negedge clk);
        check("postrst_cpu_rvalid", cpu_rvalid, 0);
        check("postrst_state", arb_state, ST_CPU_PRI);
        check("postrst_wait_cnt", arb_wait_cnt, 0);

        cyc();
        @(negedge clk);
        check("scoreboard_drain", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
